// File: rtl/pflink_pkg.sv
// Shared definitions for the pflink fast-control clock transmitter: sequencer state
// encoding, default timing constants and output decoding.
package pflink_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StQpllRst  = 3'd1,
    StQpllWait = 3'd2,
    StGtRst    = 3'd3,
    StGtWait   = 3'd4,
    StUp       = 3'd5,
    StBackoff  = 3'd6,
    StFault    = 3'd7
  } seq_state_e;

  localparam int unsigned DefQpllRstCycles = 16;
  localparam int unsigned DefSoftRstCycles = 8;
  localparam int unsigned DefLockTimeout   = 500000;
  localparam int unsigned DefDoneTimeout   = 500000;
  localparam int unsigned DefBackoffCycles = 125000;
  localparam int unsigned DefMaxRetries    = 8;
  localparam int unsigned DefCntW          = 20;

  typedef struct packed {
    logic qpll_reset;
    logic soft_reset;
    logic tx_data_valid;
    logic link_up;
    logic fault;
  } seq_out_t;

  localparam seq_out_t SeqOutReset = '{
    qpll_reset:    1'b1,
    soft_reset:    1'b1,
    tx_data_valid: 1'b0,
    link_up:       1'b0,
    fault:         1'b0
  };

  // Output levels that apply while the sequencer sits in a given state.
  function automatic seq_out_t decode_outputs(seq_state_e st);
    seq_out_t o;
    o = SeqOutReset;
    unique case (st)
      StIdle, StQpllRst, StBackoff: o = SeqOutReset;
      StQpllWait: begin
        o.qpll_reset = 1'b0;
      end
      StGtRst: begin
        o.qpll_reset    = 1'b0;
        o.tx_data_valid = 1'b1;
      end
      StGtWait: begin
        o.qpll_reset    = 1'b0;
        o.soft_reset    = 1'b0;
        o.tx_data_valid = 1'b1;
      end
      StUp: begin
        o.qpll_reset    = 1'b0;
        o.soft_reset    = 1'b0;
        o.tx_data_valid = 1'b1;
        o.link_up       = 1'b1;
      end
      StFault: begin
        o.fault = 1'b1;
      end
    endcase
    return o;
  endfunction

  function automatic logic [7:0] sat_inc8(logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pfclk_tx_sequencer_if.sv
// Control/status bundle between the clock-TX sequencer and its GTX wrapper environment.
interface pfclk_tx_sequencer_if;
  logic       enable;
  logic       qpll_lock;
  logic       qpll_refclklost;
  logic       link_pll_lock;
  logic       tx_reset_done;
  logic       qpll_reset;
  logic       soft_reset;
  logic       tx_data_valid;
  logic       link_up;
  logic       fault;
  logic [2:0] state;
  logic [7:0] retry_count;

  modport master (
    input  enable, qpll_lock, qpll_refclklost, link_pll_lock, tx_reset_done,
    output qpll_reset, soft_reset, tx_data_valid, link_up, fault, state, retry_count
  );

  modport slave (
    output enable, qpll_lock, qpll_refclklost, link_pll_lock, tx_reset_done,
    input  qpll_reset, soft_reset, tx_data_valid, link_up, fault, state, retry_count
  );
endinterface

// File: rtl/sync_bit.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_bit #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pfclk_tx_sequencer.sv
// Bring-up and recovery sequencer for the pflink clock-TX GTX channel: QPLL reset,
// lock wait, GTX soft reset, reset-done wait, link monitoring and retry with backoff.
module pfclk_tx_sequencer
  import pflink_pkg::*;
#(
  parameter int unsigned QPLL_RST_CYCLES = DefQpllRstCycles,
  parameter int unsigned SOFT_RST_CYCLES = DefSoftRstCycles,
  parameter int unsigned LOCK_TIMEOUT    = DefLockTimeout,
  parameter int unsigned DONE_TIMEOUT    = DefDoneTimeout,
  parameter int unsigned BACKOFF_CYCLES  = DefBackoffCycles,
  parameter int unsigned MAX_RETRIES     = DefMaxRetries,
  parameter int unsigned CNT_W           = DefCntW
) (
  input logic                  clk_125,
  input logic                  reset_n,
  pfclk_tx_sequencer_if.master bus
);

  localparam logic [CNT_W-1:0] QpllRstLast = CNT_W'(QPLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SoftRstLast = CNT_W'(SOFT_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LockLast    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DoneLast    = CNT_W'(DONE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BackoffLast = CNT_W'(BACKOFF_CYCLES - 1);
  localparam logic [7:0]       MaxRetries  = 8'(MAX_RETRIES);

  logic qpll_lock_s, refclklost_s, link_lock_s, lock_ok;

  sync_bit #(.ResetVal(1'b0)) u_sync_qpll_lock (
    .clk_i  (clk_125),
    .rst_ni (reset_n),
    .d_i    (bus.qpll_lock),
    .q_o    (qpll_lock_s)
  );

  sync_bit #(.ResetVal(1'b0)) u_sync_refclklost (
    .clk_i  (clk_125),
    .rst_ni (reset_n),
    .d_i    (bus.qpll_refclklost),
    .q_o    (refclklost_s)
  );

  sync_bit #(.ResetVal(1'b0)) u_sync_link_lock (
    .clk_i  (clk_125),
    .rst_ni (reset_n),
    .d_i    (bus.link_pll_lock),
    .q_o    (link_lock_s)
  );

  assign lock_ok = qpll_lock_s & link_lock_s & ~refclklost_s;

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [7:0]       attempt_q, attempt_d;
  logic [7:0]       retry_q, retry_d;
  seq_out_t         out_q;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + 1'b1;
    attempt_d = attempt_q;
    retry_d   = retry_q;

    if (!bus.enable) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: state_d = StQpllRst;
        StQpllRst: begin
          if (timer_q == QpllRstLast) state_d = StQpllWait;
        end
        StQpllWait: begin
          if (lock_ok)                    state_d = StGtRst;
          else if (timer_q == LockLast)   state_d = StBackoff;
        end
        StGtRst: begin
          if (timer_q == SoftRstLast) state_d = StGtWait;
        end
        StGtWait: begin
          // Success is tested first so it wins over a coincident timeout.
          if (bus.tx_reset_done && lock_ok)          state_d = StUp;
          else if (!lock_ok || timer_q == DoneLast)  state_d = StBackoff;
        end
        StUp: begin
          if (!lock_ok || !bus.tx_reset_done) state_d = StBackoff;
        end
        StBackoff: begin
          if (attempt_q == MaxRetries)        state_d = StFault;
          else if (timer_q == BackoffLast)    state_d = StQpllRst;
        end
        StFault: state_d = StFault;
        default: state_d = StIdle;
      endcase
    end

    if (state_d != state_q) timer_d = '0;

    if (state_d == StIdle || state_d == StUp) begin
      attempt_d = '0;
    end else if (state_d == StBackoff && state_q != StBackoff) begin
      attempt_d = sat_inc8(attempt_q);
      retry_d   = sat_inc8(retry_q);
    end
  end

  // Outputs are decoded from the next state so they switch on the same edge as state.
  always_ff @(posedge clk_125 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      attempt_q <= '0;
      retry_q   <= '0;
      out_q     <= SeqOutReset;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      attempt_q <= attempt_d;
      retry_q   <= retry_d;
      out_q     <= decode_outputs(state_d);
    end
  end

  assign bus.qpll_reset    = out_q.qpll_reset;
  assign bus.soft_reset    = out_q.soft_reset;
  assign bus.tx_data_valid = out_q.tx_data_valid;
  assign bus.link_up       = out_q.link_up;
  assign bus.fault         = out_q.fault;
  assign bus.state         = state_q;
  assign bus.retry_count   = retry_q;

endmodule

// File: tb/tb_pfclk_tx_sequencer.sv
// Directed/randomized bench for pfclk_tx_sequencer: expected state timelines are built
// from the state durations and retry rules, and every sampled cycle is checked.
module tb_pfclk_tx_sequencer;

  localparam int QRST = 4, SRST = 3, LTO = 20, DTO = 20, BOFF = 5, MAXR = 3;
  localparam int S_IDLE = 0, S_QRST = 1, S_QWAIT = 2, S_GRST = 3;
  localparam int S_GWAIT = 4, S_UP = 5, S_BOFF = 6, S_FAULT = 7;

  logic clk_125 = 1'b0;
  logic reset_n = 1'b1;

  pfclk_tx_sequencer_if bus ();

  pfclk_tx_sequencer #(
    .QPLL_RST_CYCLES (QRST),
    .SOFT_RST_CYCLES (SRST),
    .LOCK_TIMEOUT    (LTO),
    .DONE_TIMEOUT    (DTO),
    .BACKOFF_CYCLES  (BOFF),
    .MAX_RETRIES     (MAXR),
    .CNT_W           (20)
  ) dut (
    .clk_125 (clk_125),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #4 clk_125 = ~clk_125;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_retry = 0;
  int total_att = 0;

  function automatic string nm(input int s);
    string names [8];
    names = '{"IDLE", "QPLL_RST", "QPLL_WAIT", "GT_RST", "GT_WAIT", "UP", "BACKOFF", "FAULT"};
    return names[s];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference levels for each state, straight from the per-state output rules.
  task automatic check_now(input int s);
    logic qr, sr, dv;
    qr = (s == S_IDLE || s == S_QRST || s == S_BOFF || s == S_FAULT);
    sr = !(s == S_GWAIT || s == S_UP);
    dv = (s == S_GRST || s == S_GWAIT || s == S_UP);
    chk({"state@", nm(s)}, 32'(bus.state), 32'(s));
    chk({"qpll_reset@", nm(s)}, 32'(bus.qpll_reset), 32'(qr));
    chk({"soft_reset@", nm(s)}, 32'(bus.soft_reset), 32'(sr));
    chk({"tx_data_valid@", nm(s)}, 32'(bus.tx_data_valid), 32'(dv));
    chk({"link_up@", nm(s)}, 32'(bus.link_up), 32'(s == S_UP));
    chk({"fault@", nm(s)}, 32'(bus.fault), 32'(s == S_FAULT));
    chk({"retry_count@", nm(s)}, 32'(bus.retry_count), 32'(exp_retry));
  endtask

  task automatic step();
    @(posedge clk_125);
    #1;
  endtask

  task automatic run_seg(input int s, input int n);
    for (int i = 0; i < n; i++) begin
      check_now(s);
      step();
    end
  endtask

  task automatic note_backoff();
    total_att++;
    if (exp_retry < 255) exp_retry++;
  endtask

  // From an IDLE sample with locks settled and enable just raised, up to UP.
  task automatic bring_up(input int d);
    run_seg(S_IDLE, 1);
    run_seg(S_QRST, QRST);
    run_seg(S_QWAIT, 1);
    run_seg(S_GRST, SRST);
    run_seg(S_GWAIT, d);
    bus.tx_reset_done = 1'b1;
    run_seg(S_GWAIT, 1);
  endtask

  // One failed attempt starting at QPLL_RST; k is the attempt number within a round.
  task automatic fail_attempt(input bit lock_mode, input int k);
    run_seg(S_QRST, QRST);
    if (lock_mode) begin
      run_seg(S_QWAIT, LTO);
    end else begin
      run_seg(S_QWAIT, 1);
      run_seg(S_GRST, SRST);
      run_seg(S_GWAIT, DTO);
    end
    note_backoff();
    run_seg(S_BOFF, (k < MAXR) ? BOFF : 1);
  endtask

  task automatic apply_async_reset();
    #2 reset_n = 1'b0;
    #1;
    exp_retry = 0;
    check_now(S_IDLE);
  endtask

  initial begin
    bus.enable          = 1'b0;
    bus.qpll_lock       = 1'b1;
    bus.link_pll_lock   = 1'b1;
    bus.qpll_refclklost = 1'b0;
    bus.tx_reset_done   = 1'b0;

    // Reset values before any clock edge.
    #1 reset_n = 1'b0;
    #1 check_now(S_IDLE);
    step();
    step();
    reset_n = 1'b1;
    run_seg(S_IDLE, 3);

    // Clean bring-up.
    bus.enable = 1'b1;
    bring_up(6);
    run_seg(S_UP, 3);

    // Enable drop in UP, then in GT_WAIT.
    bus.enable = 1'b0;
    run_seg(S_UP, 1);
    run_seg(S_IDLE, 2);
    bus.tx_reset_done = 1'b0;
    bus.enable = 1'b1;
    run_seg(S_IDLE, 1);
    run_seg(S_QRST, QRST);
    run_seg(S_QWAIT, 1);
    run_seg(S_GRST, SRST);
    run_seg(S_GWAIT, $urandom_range(0, 15));
    bus.enable = 1'b0;
    run_seg(S_GWAIT, 1);
    run_seg(S_IDLE, 1);

    // Lock timeout to FAULT, then enable drop out of FAULT.
    bus.qpll_lock = 1'b0;
    run_seg(S_IDLE, 3);
    bus.enable = 1'b1;
    run_seg(S_IDLE, 1);
    for (int k = 1; k <= MAXR; k++) fail_attempt(1'b1, k);
    run_seg(S_FAULT, 3);
    chk("retry_after_fault", 32'(bus.retry_count), 32'd3);
    bus.enable = 1'b0;
    run_seg(S_FAULT, 1);
    run_seg(S_IDLE, 1);

    // Asynchronous reset in the middle of GT_RST.
    bus.qpll_lock = 1'b1;
    run_seg(S_IDLE, 3);
    bus.enable = 1'b1;
    run_seg(S_IDLE, 1);
    run_seg(S_QRST, QRST);
    run_seg(S_QWAIT, 1);
    run_seg(S_GRST, 1);
    apply_async_reset();
    bus.enable = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    run_seg(S_IDLE, 3);

    // One-cycle refclk loss while UP: BACKOFF on the third edge, then recovery.
    bus.enable = 1'b1;
    bring_up($urandom_range(0, 15));
    run_seg(S_UP, 2);
    bus.qpll_refclklost = 1'b1;
    run_seg(S_UP, 1);
    bus.qpll_refclklost = 1'b0;
    run_seg(S_UP, 2);
    note_backoff();
    bus.tx_reset_done = 1'b0;
    run_seg(S_BOFF, BOFF);
    run_seg(S_QRST, QRST);
    run_seg(S_QWAIT, 1);
    run_seg(S_GRST, SRST);
    run_seg(S_GWAIT, $urandom_range(0, 15));
    bus.tx_reset_done = 1'b1;
    run_seg(S_GWAIT, 1);
    run_seg(S_UP, 3);
    chk("retry_after_drop", 32'(bus.retry_count), 32'd1);

    // Reset-done loss while UP leaves on the next edge.
    bus.tx_reset_done = 1'b0;
    run_seg(S_UP, 1);
    note_backoff();
    run_seg(S_BOFF, BOFF);
    run_seg(S_QRST, QRST);
    run_seg(S_QWAIT, 1);
    run_seg(S_GRST, SRST);
    bus.tx_reset_done = 1'b1;
    run_seg(S_GWAIT, 1);
    run_seg(S_UP, 2);
    bus.enable = 1'b0;
    run_seg(S_UP, 1);
    run_seg(S_IDLE, 1);

    // Saturation: rounds of three random-kind failures until well past 255 retries.
    while (total_att < 260) begin
      bit lock_mode;
      lock_mode = 1'($urandom_range(0, 1));
      bus.qpll_lock = !lock_mode;
      bus.tx_reset_done = 1'b0;
      run_seg(S_IDLE, 3);
      bus.enable = 1'b1;
      run_seg(S_IDLE, 1);
      for (int k = 1; k <= MAXR; k++) fail_attempt(lock_mode, k);
      run_seg(S_FAULT, 1);
      bus.enable = 1'b0;
      run_seg(S_FAULT, 1);
      run_seg(S_IDLE, 1);
    end
    chk("retry_saturated", 32'(bus.retry_count), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
